// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and helpers for the memory-stage access controller
package mem_stage_pkg;

  localparam int RES_SRC_W  = 2;
  localparam int REG_ADDR_W = 5;

  // Writeback result selector; encoding 2'b11 is reserved and behaves like RES_ALU.
  typedef enum logic [RES_SRC_W-1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } results_src_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // An instruction needs the data memory when it stores or when its result comes from a load.
  function automatic logic is_mem_op(input logic valid,
                                     input logic mem_write,
                                     input logic [RES_SRC_W-1:0] res_src);
    return valid & (mem_write | (res_src == RES_MEM));
  endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_if.sv
// rtl/mem_stage_access_ctrl_if.sv - req/ack data-memory bus between the memory stage and data memory
interface mem_stage_access_ctrl_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  req;
  logic                  we;
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ack;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);

endinterface

// File: rtl/mem_wb_output_reg.sv
// rtl/mem_wb_output_reg.sv - MEM/WB pipeline bundle register with load enable
module mem_wb_output_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_d_i,
  input  logic                  load_i,
  input  logic                  regwrite_d_i,
  input  logic [RES_SRC_W-1:0]  res_src_d_i,
  input  logic [DATA_WIDTH-1:0] alu_result_d_i,
  input  logic [DATA_WIDTH-1:0] read_data_d_i,
  input  logic [REG_ADDR_W-1:0] rd_d_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_d_i,
  output logic                  valid_o,
  output logic                  regwrite_o,
  output logic [RES_SRC_W-1:0]  res_src_o,
  output logic [DATA_WIDTH-1:0] alu_result_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  logic                  valid_q;
  logic                  regwrite_q;
  logic [RES_SRC_W-1:0]  res_src_q;
  logic [DATA_WIDTH-1:0] alu_result_q;
  logic [DATA_WIDTH-1:0] read_data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [DATA_WIDTH-1:0] pc_plus4_q;

  // valid follows every cycle; the payload only refreshes on load so it holds through bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      regwrite_q   <= 1'b0;
      res_src_q    <= '0;
      alu_result_q <= '0;
      read_data_q  <= '0;
      rd_q         <= '0;
      pc_plus4_q   <= '0;
    end else begin
      valid_q <= valid_d_i;
      if (load_i) begin
        regwrite_q   <= regwrite_d_i;
        res_src_q    <= res_src_d_i;
        alu_result_q <= alu_result_d_i;
        read_data_q  <= read_data_d_i;
        rd_q         <= rd_d_i;
        pc_plus4_q   <= pc_plus4_d_i;
      end
    end
  end

  assign valid_o      = valid_q;
  assign regwrite_o   = regwrite_q;
  assign res_src_o    = res_src_q;
  assign alu_result_o = alu_result_q;
  assign read_data_o  = read_data_q;
  assign rd_o         = rd_q;
  assign pc_plus4_o   = pc_plus4_q;

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// rtl/mem_stage_access_ctrl.sv - memory stage: load/store decode, req/ack access FSM, timeout watchdog
module mem_stage_access_ctrl
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    valid_i,
  input  logic                    RegWrite_i,
  input  logic [RES_SRC_W-1:0]    ResultsSrc_i,
  input  logic                    MemWrite_i,
  input  logic [DATA_WIDTH-1:0]   ALUResult_i,
  input  logic [DATA_WIDTH-1:0]   WriteData_i,
  input  logic [REG_ADDR_W-1:0]   Rd_i,
  input  logic [DATA_WIDTH-1:0]   PCPlus4_i,
  output logic                    stall_o,
  mem_stage_access_ctrl_if.master mem,
  output logic                    valid_o,
  output logic                    RegWrite_o,
  output logic [RES_SRC_W-1:0]    ResultsSrc_o,
  output logic [DATA_WIDTH-1:0]   ALUResult_o,
  output logic [DATA_WIDTH-1:0]   ReadData_o,
  output logic [REG_ADDR_W-1:0]   Rd_o,
  output logic [DATA_WIDTH-1:0]   PCPlus4_o,
  output logic                    err_o
);

  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  err_q;
  logic                  lat_we_q;
  logic                  lat_load_q;
  logic                  lat_rw_q;
  logic [RES_SRC_W-1:0]  lat_src_q;
  logic [DATA_WIDTH-1:0] lat_addr_q;
  logic [DATA_WIDTH-1:0] lat_wdata_q;
  logic [REG_ADDR_W-1:0] lat_rd_q;
  logic [DATA_WIDTH-1:0] lat_pc4_q;

  logic                  mem_op;
  logic                  wb_valid_d;
  logic                  wb_load_d;
  logic                  wb_rw_d;
  logic [RES_SRC_W-1:0]  wb_src_d;
  logic [DATA_WIDTH-1:0] wb_alu_d;
  logic [DATA_WIDTH-1:0] wb_rdata_d;
  logic [REG_ADDR_W-1:0] wb_rd_d;
  logic [DATA_WIDTH-1:0] wb_pc4_d;

  assign mem_op = is_mem_op(valid_i, MemWrite_i, ResultsSrc_i);

  // Access FSM: latch the memory op, hold it on the bus until ack or the watchdog expires
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_load_q  <= 1'b0;
      lat_rw_q    <= 1'b0;
      lat_src_q   <= '0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_rd_q    <= '0;
      lat_pc4_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op) begin
            state_q     <= ACCESS;
            cnt_q       <= '0;
            lat_we_q    <= MemWrite_i;
            lat_load_q  <= ~MemWrite_i & (ResultsSrc_i == RES_MEM);
            lat_rw_q    <= RegWrite_i;
            lat_src_q   <= ResultsSrc_i;
            lat_addr_q  <= ALUResult_i;
            lat_wdata_q <= WriteData_i;
            lat_rd_q    <= Rd_i;
            lat_pc4_q   <= PCPlus4_i;
          end
        end
        ACCESS: begin
          // an ack arriving in the last permitted cycle still completes normally
          if (mem.ack) begin
            state_q <= IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Next MEM/WB contents: pass-through ops from IDLE, latched op on completion or squash
  always_comb begin
    wb_valid_d = 1'b0;
    wb_load_d  = 1'b0;
    wb_rw_d    = RegWrite_i;
    wb_src_d   = ResultsSrc_i;
    wb_alu_d   = ALUResult_i;
    wb_rdata_d = '0;
    wb_rd_d    = Rd_i;
    wb_pc4_d   = PCPlus4_i;
    if (state_q == IDLE) begin
      if (valid_i & ~mem_op) begin
        wb_valid_d = 1'b1;
        wb_load_d  = 1'b1;
      end
    end else begin
      wb_rw_d  = lat_rw_q;
      wb_src_d = lat_src_q;
      wb_alu_d = lat_addr_q;
      wb_rd_d  = lat_rd_q;
      wb_pc4_d = lat_pc4_q;
      if (mem.ack) begin
        wb_valid_d = 1'b1;
        wb_load_d  = 1'b1;
        wb_rdata_d = lat_load_q ? mem.rdata : '0;
      end else if (cnt_q == CNT_LAST) begin
        wb_valid_d = 1'b1;
        wb_load_d  = 1'b1;
        wb_rw_d    = 1'b0;
      end
    end
  end

  assign stall_o   = (state_q == ACCESS);
  assign mem.req   = (state_q == ACCESS);
  assign mem.we    = lat_we_q;
  assign mem.addr  = lat_addr_q;
  assign mem.wdata = lat_wdata_q;
  assign err_o     = err_q;

  mem_wb_output_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem_wb (
    .clk            (clk),
    .rst            (rst),
    .valid_d_i      (wb_valid_d),
    .load_i         (wb_load_d),
    .regwrite_d_i   (wb_rw_d),
    .res_src_d_i    (wb_src_d),
    .alu_result_d_i (wb_alu_d),
    .read_data_d_i  (wb_rdata_d),
    .rd_d_i         (wb_rd_d),
    .pc_plus4_d_i   (wb_pc4_d),
    .valid_o        (valid_o),
    .regwrite_o     (RegWrite_o),
    .res_src_o      (ResultsSrc_o),
    .alu_result_o   (ALUResult_o),
    .read_data_o    (ReadData_o),
    .rd_o           (Rd_o),
    .pc_plus4_o     (PCPlus4_o)
  );

endmodule
